l2_mem_responder: RTL and testbench

- Line-granularity memory responder that sits at the L2 end of the arbiter's mem_read/mem_write/mem_address/mem_wdata interface.
- Answers each request with a single-cycle mem_resp after a fixed latency; serves 128-bit lines.
- Used as the physical-memory model behind the arbiter for system simulation, and as the backing store for L2 bring-up.

---
 rtl/l2_mem_responder.sv | 150 +++++++++++++++
 tb/tb_l2_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : l2_mem_responder
// Description : Line-granularity memory responder for the L2 side of the
//               arbiter interface. Each accepted request completes with a
//               single-cycle mem_resp exactly LATENCY cycles after the cycle
//               in which it was sampled. Serves 128-bit lines. Used as the
//               physical-memory model behind the arbiter and as the backing
//               store for L2 bring-up.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH_LINES : number of 128-bit lines (power of two, 2..4096)
//   LATENCY     : request-to-response latency in cycles (1..255)
// Ports
//   clk         in   1    clock, all state updates on the rising edge
//   reset       in   1    synchronous, active-high reset
//   mem_read    in   1    read request, held until mem_resp
//   mem_write   in   1    write request, held until mem_resp
//   mem_address in   16   byte address; [3:0] ignored, [15:4] = line
//   mem_wdata   in   128  write line data
//   mem_resp    out  1    one-cycle completion pulse
//   mem_rdata   out  128  line data, valid while mem_resp is high
//   busy        out  1    high from acceptance through the mem_resp cycle
//   read_count  out  16   completed reads (wraps)
//   write_count out  16   completed writes (wraps)
// ============================================================================
module l2_mem_responder #(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic         mem_resp,
    output logic [127:0] mem_rdata,
    output logic         busy,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
);

    localparam int         c_IDX_W   = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam logic [7:0] c_CNT_LOAD = 8'(LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    // Line storage: zero at elaboration, deliberately untouched by reset so
    // a reset during bring-up does not wipe the memory image.
    logic [127:0]         r_mem [DEPTH_LINES] = '{default: '0};

    logic [1:0]           r_state;
    logic [7:0]           r_cnt;
    logic                 r_op_wr;
    logic [c_IDX_W-1:0]   r_idx;
    logic [127:0]         r_wdata;

    logic [c_IDX_W-1:0]   w_req_idx;
    logic                 w_req;
    logic                 w_commit;
    logic                 w_unused_addr;

    // Lines are 16 bytes; the low index bits of the line number select the
    // entry, so addresses beyond the array wrap modulo DEPTH_LINES.
    assign w_req_idx     = mem_address[4 +: c_IDX_W];
    assign w_req         = mem_read | mem_write;
    assign w_unused_addr = ^mem_address;

    // A write lands at the end of its response cycle; a reset sampled on
    // that same edge aborts it.
    assign w_commit = !reset && (r_state == c_ST_RESP) && r_op_wr;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 8'd0;
            r_op_wr     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            mem_resp    <= 1'b0;
            mem_rdata   <= '0;
            busy        <= 1'b0;
            read_count  <= 16'd0;
            write_count <= 16'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    mem_resp <= 1'b0;
                    if (w_req) begin
                        // Write wins when both strobes are high.
                        r_op_wr <= mem_write;
                        r_idx   <= w_req_idx;
                        r_wdata <= mem_wdata;
                        r_cnt   <= c_CNT_LOAD;
                        busy    <= 1'b1;
                        if (LATENCY == 1) begin
                            // No wait phase: the response is presented in the
                            // very next cycle, read straight from the request.
                            r_state   <= c_ST_RESP;
                            mem_resp  <= 1'b1;
                            mem_rdata <= r_mem[w_req_idx];
                        end else begin
                            r_state <= c_ST_WAIT;
                        end
                    end
                end

                c_ST_WAIT: begin
                    // Inputs are ignored here; only the latched request counts.
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state   <= c_ST_RESP;
                        mem_resp  <= 1'b1;
                        // Writes also return the pre-write line contents.
                        mem_rdata <= r_mem[r_idx];
                    end
                end

                c_ST_RESP: begin
                    mem_resp <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= c_ST_IDLE;
                    if (r_op_wr) begin
                        write_count <= write_count + 16'd1;
                    end else begin
                        read_count <= read_count + 16'd1;
                    end
                end

                default: begin
                    r_state  <= c_ST_IDLE;
                    mem_resp <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_mem_responder
// Description : Self-checking bench for l2_mem_responder. Instance 0 uses
//               DEPTH_LINES=256 / LATENCY=4, instance 1 DEPTH_LINES=16 /
//               LATENCY=1. A transaction-level model predicts every output on
//               every cycle; directed tests add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_mem_responder;

    localparam logic [127:0] c_D1   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] c_D2   = 128'hA5A5A5A5_5A5A5A5A_11112222_33334444;
    localparam logic [127:0] c_D3   = 128'hDEADBEEF_CAFEF00D_00000001_80000000;
    localparam logic [127:0] c_D4   = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    localparam logic [127:0] c_D5   = 128'h55555555_AAAAAAAA_13579BDF_2468ACE0;
    localparam logic [127:0] c_D6   = 128'h00000000_FFFFFFFF_87654321_0FEDCBA9;
    localparam logic [127:0] c_ONES = {128{1'b1}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         rst;
    logic [1:0]         rd;
    logic [1:0]         wr;
    logic [1:0][15:0]   addr;
    logic [1:0][127:0]  wdata;
    wire  [1:0]         resp;
    wire  [1:0][127:0]  rdata;
    wire  [1:0]         busy;
    wire  [1:0][15:0]   rc;
    wire  [1:0][15:0]   wc;

    l2_mem_responder #(.DEPTH_LINES(256), .LATENCY(4)) u_dut0 (
        .clk(clk), .reset(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_address(addr[0]), .mem_wdata(wdata[0]), .mem_resp(resp[0]),
        .mem_rdata(rdata[0]), .busy(busy[0]), .read_count(rc[0]),
        .write_count(wc[0])
    );

    l2_mem_responder #(.DEPTH_LINES(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_address(addr[1]), .mem_wdata(wdata[1]), .mem_resp(resp[1]),
        .mem_rdata(rdata[1]), .busy(busy[1]), .read_count(rc[1]),
        .write_count(wc[1])
    );

    function automatic int depth_of(input int i);
        return (i == 0) ? 256 : 16;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_resp_cyc [2];

    task automatic chk(input string name, input int inst,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h", name, inst, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: a request seen while idle occupies cycles
    // 1..LAT after acceptance, responds in cycle LAT with the line's
    // current content, then commits/counts on the edge that ends cycle LAT.
    // ------------------------------------------------------------------
    logic [127:0] m_mem [2][256];
    bit           m_valid  [2];
    bit           m_active [2];
    int           m_cyc    [2];
    bit           m_wr     [2];
    int           m_idx    [2];
    logic [127:0] m_data   [2];
    logic         e_resp   [2];
    logic         e_busy   [2];
    logic [127:0] e_rdata  [2];
    logic [15:0]  e_rc     [2];
    logic [15:0]  e_wc     [2];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_valid[i]  = 1'b1;
                m_active[i] = 1'b0;
                e_resp[i]   = 1'b0;
                e_busy[i]   = 1'b0;
                e_rdata[i]  = '0;
                e_rc[i]     = 16'd0;
                e_wc[i]     = 16'd0;
            end else if (m_active[i]) begin
                if (m_cyc[i] == lat_of(i)) begin
                    if (m_wr[i]) begin
                        m_mem[i][m_idx[i]] = m_data[i];
                        e_wc[i] = e_wc[i] + 16'd1;
                    end else begin
                        e_rc[i] = e_rc[i] + 16'd1;
                    end
                    m_active[i] = 1'b0;
                    e_resp[i]   = 1'b0;
                    e_busy[i]   = 1'b0;
                end else begin
                    m_cyc[i] = m_cyc[i] + 1;
                    if (m_cyc[i] == lat_of(i)) begin
                        e_resp[i]  = 1'b1;
                        e_rdata[i] = m_mem[i][m_idx[i]];
                    end
                end
            end else if (rd[i] || wr[i]) begin
                m_active[i] = 1'b1;
                m_cyc[i]    = 1;
                m_wr[i]     = wr[i];
                m_idx[i]    = int'(addr[i][15:4]) % depth_of(i);
                m_data[i]   = wdata[i];
                e_busy[i]   = 1'b1;
                if (lat_of(i) == 1) begin
                    e_resp[i]  = 1'b1;
                    e_rdata[i] = m_mem[i][m_idx[i]];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i]) begin
                chk("mem_resp",    i, 128'(resp[i]), 128'(e_resp[i]));
                chk("busy",        i, 128'(busy[i]), 128'(e_busy[i]));
                chk("mem_rdata",   i, rdata[i],      e_rdata[i]);
                chk("read_count",  i, 128'(rc[i]),   128'(e_rc[i]));
                chk("write_count", i, 128'(wc[i]),   128'(e_wc[i]));
            end
        end
    end

    // mode: 0 plain, 1 change address/data during WAIT, 2 drop request
    // during WAIT, 3 assert reset in the response cycle.
    // Entered and left at #1 after a rising edge; the caller's next request
    // may start immediately, giving back-to-back issue.
    task automatic req(input int i, input bit r, input bit w,
                       input logic [15:0] a, input logic [127:0] d,
                       input int mode, output int lat, output logic [127:0] seen);
        rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d;
        lat  = -1;
        seen = '0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp[i]) begin
                lat  = k;
                seen = rdata[i];
                last_resp_cyc[i] = cyc;
                if (mode == 3) rst[i] = 1'b1;
                break;
            end
            if (k == 1 && mode == 1) begin
                addr[i]  = ~a;
                wdata[i] = ~d;
            end
            if (k == 1 && mode == 2) begin
                rd[i] = 1'b0;
                wr[i] = 1'b0;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout inst%0d: got no mem_resp expected one within 300 cycles", i);
        end
        @(posedge clk);
        #1;
        rd[i]  = 1'b0;
        wr[i]  = 1'b0;
        rst[i] = 1'b0;
    endtask

    initial begin
        int           lat;
        int           c1;
        logic [127:0] seen;

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 256; j++)
                m_mem[i][j] = '0;
        rst = 2'b11; rd = 2'b00; wr = 2'b00; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;
        @(negedge clk);
        chk("reset_resp",  0, 128'(resp[0]), 128'd0);
        chk("reset_busy",  0, 128'(busy[0]), 128'd0);
        chk("reset_rdata", 0, rdata[0],      128'd0);
        chk("reset_wc",    0, 128'(wc[0]),   128'd0);
        @(posedge clk);
        #1;

        // Write then read back through offset bits.
        req(0, 1'b0, 1'b1, 16'h0040, c_D1, 0, lat, seen);
        chk("w1_latency", 0, 128'(lat), 128'd4);
        chk("w1_wcount",  0, 128'(wc[0]), 128'd1);
        req(0, 1'b1, 1'b0, 16'h004C, '0, 0, lat, seen);
        chk("r1_latency", 0, 128'(lat), 128'd4);
        chk("r1_data",    0, seen, c_D1);
        chk("r1_rcount",  0, 128'(rc[0]), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("r1_hold", 0, rdata[0], c_D1);

        // Back-to-back reads of unwritten lines.
        req(0, 1'b1, 1'b0, 16'h0000, '0, 0, lat, seen);
        chk("b2b_a_data", 0, seen, 128'd0);
        c1 = last_resp_cyc[0];
        req(0, 1'b1, 1'b0, 16'h0010, '0, 0, lat, seen);
        chk("b2b_b_data", 0, seen, 128'd0);
        chk("b2b_spacing", 0, 128'(last_resp_cyc[0] - c1), 128'd5);

        // Read and write together: write wins, old line returned.
        req(0, 1'b1, 1'b1, 16'h0040, c_ONES, 0, lat, seen);
        chk("rw_old_data", 0, seen, c_D1);
        chk("rw_wcount",   0, 128'(wc[0]), 128'd2);
        chk("rw_rcount",   0, 128'(rc[0]), 128'd3);
        req(0, 1'b1, 1'b0, 16'h0040, '0, 0, lat, seen);
        chk("rw_new_data", 0, seen, c_ONES);

        // Address/data changes during WAIT are ignored.
        req(0, 1'b0, 1'b1, 16'h0080, c_D2, 1, lat, seen);
        req(0, 1'b1, 1'b0, 16'h0080, '0, 0, lat, seen);
        chk("latch_data", 0, seen, c_D2);
        req(0, 1'b1, 1'b0, 16'hFF70, '0, 0, lat, seen);
        chk("latch_other_line", 0, seen, 128'd0);

        // Request dropped mid-flight still completes.
        req(0, 1'b0, 1'b1, 16'h0090, c_D6, 2, lat, seen);
        chk("drop_latency", 0, 128'(lat), 128'd4);
        req(0, 1'b1, 1'b0, 16'h0090, '0, 0, lat, seen);
        chk("drop_data", 0, seen, c_D6);

        // Index wraps modulo DEPTH_LINES.
        req(0, 1'b0, 1'b1, 16'h1000, c_D3, 0, lat, seen);
        req(0, 1'b1, 1'b0, 16'h0000, '0, 0, lat, seen);
        chk("wrap0_data", 0, seen, c_D3);

        // Reset in cycle 2 of a write: aborted, nothing committed.
        wr[0] = 1'b1; addr[0] = 16'h0040; wdata[0] = c_D4;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        wr[0]  = 1'b0;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        chk("rstw_wcount", 0, 128'(wc[0]), 128'd0);
        chk("rstw_rcount", 0, 128'(rc[0]), 128'd0);
        @(posedge clk);
        #1;
        req(0, 1'b1, 1'b0, 16'h0040, '0, 0, lat, seen);
        chk("rstw_data", 0, seen, c_ONES);

        // Reset coinciding with the response cycle.
        req(0, 1'b0, 1'b1, 16'h0040, c_D4, 3, lat, seen);
        chk("rstr_latency", 0, 128'(lat), 128'd4);
        chk("rstr_wcount",  0, 128'(wc[0]), 128'd0);
        chk("rstr_rcount",  0, 128'(rc[0]), 128'd0);
        req(0, 1'b1, 1'b0, 16'h0040, '0, 0, lat, seen);
        chk("rstr_data", 0, seen, c_ONES);

        // Small, single-cycle-latency instance.
        req(1, 1'b0, 1'b1, 16'h0100, c_D5, 0, lat, seen);
        chk("i1_w_latency", 1, 128'(lat), 128'd1);
        req(1, 1'b1, 1'b0, 16'h0000, '0, 0, lat, seen);
        chk("i1_r_latency", 1, 128'(lat), 128'd1);
        chk("i1_wrap_data", 1, seen, c_D5);
        chk("i1_rcount",    1, 128'(rc[1]), 128'd1);
        chk("i1_wcount",    1, 128'(wc[1]), 128'd1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
